// File: rtl/sensor_debounce.sv
// Dual-channel debouncer/edge detector for the parking-meter car sensors.
// Optional macro SENSOR_SYNC_EN adds a two-flop input synchronizer per channel.

module DebounceChannel #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic s_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {
    ZERO,
    WAIT1,
    ONE,
    WAIT0
  } state_t;

  // The entering sample already counts as the first of DB_CYCLES equal samples.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DB_CYCLES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (s_i) begin
          state_d = WAIT1;
          cnt_d   = LOAD;
        end
      end
      WAIT1: begin
        if (!s_i) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ONE: begin
        if (!s_i) begin
          state_d = WAIT0;
          cnt_d   = LOAD;
        end
      end
      WAIT0: begin
        if (s_i) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db_o   = (state_q == ONE) || (state_q == WAIT0);
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

module sensor_debounce #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  logic aSample;
  logic bSample;

`ifdef SENSOR_SYNC_EN
  // Raw sensor pins are asynchronous; two flops settle metastability before the FSM.
  logic [1:0] aSync_q;
  logic [1:0] bSync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      aSync_q <= 2'b00;
      bSync_q <= 2'b00;
    end else begin
      aSync_q <= {aSync_q[0], a_in};
      bSync_q <= {bSync_q[0], b_in};
    end
  end

  assign aSample = aSync_q[1];
  assign bSample = bSync_q[1];
`else
  assign aSample = a_in;
  assign bSample = b_in;
`endif

  DebounceChannel #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) uChanA (
    .clk   (clk),
    .reset (reset),
    .s_i   (aSample),
    .db_o  (a_db),
    .rise_o(a_rise),
    .fall_o(a_fall)
  );

  DebounceChannel #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) uChanB (
    .clk   (clk),
    .reset (reset),
    .s_i   (bSample),
    .db_o  (b_db),
    .rise_o(b_rise),
    .fall_o(b_fall)
  );

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce with DB_CYCLES=4.
// Expectations come from a run-length model and a vector table, delayed via a scoreboard queue.

module tb_sensor_debounce;

  localparam int DB = 4;
  localparam int CW = 3;
`ifdef SENSOR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall;

  always #5 clk = ~clk;

  sensor_debounce #(
    .DB_CYCLES(DB),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a_in  (a_in),
    .b_in  (b_in),
    .a_db  (a_db),
    .b_db  (b_db),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  typedef struct packed {
    logic aDb;
    logic aRise;
    logic aFall;
    logic bDb;
    logic bRise;
    logic bFall;
  } outs_t;

  typedef struct {
    logic  aIn;
    logic  bIn;
    outs_t exp;
  } vec_t;

  vec_t  vecs[23];
  outs_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: count consecutive samples that disagree with the accepted level.
  logic mDbA = 1'b0, mDbB = 1'b0;
  int   runA = 0, runB = 0;

  function automatic void modelChannel(input logic s, inout logic db, inout int run,
                                       output logic rise, output logic fall);
    rise = 1'b0;
    fall = 1'b0;
    if (s != db) begin
      run++;
      if (run == DB) begin
        db   = s;
        rise = s;
        fall = ~s;
        run  = 0;
      end
    end else begin
      run = 0;
    end
  endfunction

  function automatic outs_t dutOuts();
    outs_t o;
    o = '{aDb: a_db, aRise: a_rise, aFall: a_fall, bDb: b_db, bRise: b_rise, bFall: b_fall};
    return o;
  endfunction

  function automatic vec_t mkVec(input logic a, input logic b, input logic [5:0] e);
    vec_t v;
    v.aIn = a;
    v.bIn = b;
    v.exp = outs_t'(e);
    return v;
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual={aDb,aRise,aFall,bDb,bRise,bFall}=%b required=%b",
               name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample #1 after posedge, push expectation, pop once latency is covered.
  task automatic applyStimulus(input logic a, input logic b, input logic rst,
                               input logic useVec, input outs_t vecExp, input string name);
    outs_t mExp;
    outs_t e;
    logic  rA, fA, rB, fB;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      mDbA = 1'b0; runA = 0;
      mDbB = 1'b0; runB = 0;
      expQ.delete();
      checkOutput({name, "_reset"}, dutOuts(), '0);
    end else begin
      modelChannel(a, mDbA, runA, rA, fA);
      modelChannel(b, mDbB, runB, rB, fB);
      mExp = '{aDb: mDbA, aRise: rA, aFall: fA, bDb: mDbB, bRise: rB, bFall: fB};
      expQ.push_back(useVec ? vecExp : mExp);
      if (expQ.size() > SYNC_LAT) begin
        e = expQ.pop_front();
        checkOutput(name, dutOuts(), e);
      end
    end
  endtask

  // Holds the inputs and counts clocks until the selected pulse appears (bounded).
  task automatic measure(input string name, input logic a, input logic b,
                         input int which, input int expLat);
    int   lat;
    logic found;
    logic p;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(a, b, 1'b0, 1'b0, '0, name);
      lat++;
      case (which)
        0:       p = a_rise;
        1:       p = a_fall;
        2:       p = b_rise;
        default: p = b_fall;
      endcase
      if (p === 1'b1) found = 1'b1;
    end
    if (!found) lat = -1;
    checkInt({name, "_latency"}, lat, expLat);
  endtask

  logic rndA, rndB;

  initial begin
    vecs[0]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[1]  = mkVec(1'b0, 1'b0, 6'b000000);
    vecs[2]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[3]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[4]  = mkVec(1'b0, 1'b0, 6'b000000);
    vecs[5]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[6]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[7]  = mkVec(1'b1, 1'b0, 6'b000000);
    vecs[8]  = mkVec(1'b1, 1'b0, 6'b110000);
    vecs[9]  = mkVec(1'b1, 1'b0, 6'b100000);
    vecs[10] = mkVec(1'b1, 1'b1, 6'b100000);
    vecs[11] = mkVec(1'b1, 1'b1, 6'b100000);
    vecs[12] = mkVec(1'b1, 1'b1, 6'b100000);
    vecs[13] = mkVec(1'b1, 1'b0, 6'b100000);
    vecs[14] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[15] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[16] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[17] = mkVec(1'b1, 1'b0, 6'b100000);
    vecs[18] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[19] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[20] = mkVec(1'b0, 1'b0, 6'b100000);
    vecs[21] = mkVec(1'b0, 1'b0, 6'b001000);
    vecs[22] = mkVec(1'b0, 1'b0, 6'b000000);

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, "reset");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "idle");

    $display("[TB] clean rise and fall");
    measure("cleanRise", 1'b1, 1'b0, 0, DB + SYNC_LAT);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, "holdHigh");
    measure("cleanFall", 1'b0, 1'b0, 1, DB + SYNC_LAT);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "holdLow");

    $display("[TB] bounce table");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, "tableReset");
    for (int i = 0; i < 23; i++)
      applyStimulus(vecs[i].aIn, vecs[i].bIn, 1'b0, 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "tableFlush");

    $display("[TB] simultaneous channels");
    measure("bothRise", 1'b1, 1'b1, 0, DB + SYNC_LAT);
    checkInt("bothRiseB", int'(b_rise), 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, "bothHigh");
    measure("onlyBFall", 1'b1, 1'b0, 3, DB + SYNC_LAT);
    checkInt("onlyBFallA", int'(a_fall), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, "aOnlyHigh");

    $display("[TB] reset during WAIT0");
    for (int i = 0; i < 2 + SYNC_LAT; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, "dropA");
    checkInt("wait0Db", int'(a_db), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, "midReset");
    measure("requalify", 1'b1, 1'b0, 0, DB + SYNC_LAT);

    $display("[TB] random bounce");
    rndA = 1'b1;
    rndB = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rndA = ~rndA;
      if ($urandom_range(0, 4) == 0) rndB = ~rndB;
      applyStimulus(rndA, rndB, 1'b0, 1'b0, '0, "random");
    end
    for (int i = 0; i < 8; i++) applyStimulus(rndA, rndB, 1'b0, 1'b0, '0, "finalFlush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
